// File: rtl/secded_decoder.sv
// -----------------------------------------------------------------------------
// secded_decoder
//
// Two-stage pipelined SECDED (39,32) Hamming decoder with valid/ready streams
// on both sides. Stage 1 registers the codeword together with its 6-bit
// syndrome and overall parity. Stage 2 registers the corrected data, the
// single/double error flags and the corrected bit position.
//
// Codeword layout (index i, position j = i + 1):
//   Hamming parity p0..p5 at i = 0, 1, 3, 7, 15, 31
//   overall parity at i = 38
//   data[0..31] at i = 2, 4-6, 8-14, 16-30, 32-37 in ascending order
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A producer holds valid and its payload stable until that edge.
// in_ready is combinational from out_ready; no other input reaches an output
// without passing through a register.
//
// Optional feature macro: SECDED_DEC_ERR_CNT_EN
//   defined   -> saturating corr_cnt / uncorr_cnt counters, cleared by cnt_clr
//   undefined -> counters tied to 0, cnt_clr ignored
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    codeword valid
//   in_ready    decoder can accept a codeword
//   enc_data    39-bit codeword
//   out_valid   decoded word valid
//   out_ready   downstream accepts the word
//   data        corrected data (raw extraction on double_err)
//   single_err  one bit corrected in this word
//   double_err  uncorrectable error in this word
//   err_pos     codeword index of the corrected bit, 0 when single_err = 0
//   cnt_clr     synchronous clear of both counters (wins over an increment)
//   corr_cnt    words delivered with single_err (saturating)
//   uncorr_cnt  words delivered with double_err (saturating)
// -----------------------------------------------------------------------------
module secded_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [38:0]      enc_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      data,
    output logic             single_err,
    output logic             double_err,
    output logic [5:0]       err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    // Syndrome masks over indices 0..37: bit i is set when (i+1) has bit k set.
    localparam logic [37:0] SYN_M0 = 38'h15_5555_5555;
    localparam logic [37:0] SYN_M1 = 38'h26_6666_6666;
    localparam logic [37:0] SYN_M2 = 38'h38_7878_7878;
    localparam logic [37:0] SYN_M3 = 38'h00_7F80_7F80;
    localparam logic [37:0] SYN_M4 = 38'h00_7FFF_8000;
    localparam logic [37:0] SYN_M5 = 38'h3F_8000_0000;

    // Pull the 32 data bits out of their codeword positions.
    function automatic logic [31:0] extract(input logic [38:0] c);
        return {c[37:32], c[30:16], c[14:8], c[6:4], c[2]};
    endfunction

    // ---------------------------------------------------------------- control
    logic s1_valid;
    logic s2_load;
    logic s1_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ---------------------------------------------------------------- stage 1
    logic [5:0]  syn;
    logic        ovr;
    logic [38:0] s1_code;
    logic [5:0]  s1_syn;
    logic        s1_ovr;

    always_comb begin
        syn[0] = ^(enc_data[37:0] & SYN_M0);
        syn[1] = ^(enc_data[37:0] & SYN_M1);
        syn[2] = ^(enc_data[37:0] & SYN_M2);
        syn[3] = ^(enc_data[37:0] & SYN_M3);
        syn[4] = ^(enc_data[37:0] & SYN_M4);
        syn[5] = ^(enc_data[37:0] & SYN_M5);
        ovr    = ^enc_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_ovr   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= enc_data;
                s1_syn  <= syn;
                s1_ovr  <= ovr;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [38:0] fixed;
    logic [31:0] dec_data;
    logic        dec_single;
    logic        dec_double;
    logic [5:0]  dec_pos;

    always_comb begin
        fixed      = s1_code;
        dec_single = 1'b0;
        dec_double = 1'b0;
        dec_pos    = '0;
        if (s1_syn == 6'd0) begin
            // Only the overall parity bit can be wrong; data is untouched.
            if (s1_ovr) begin
                dec_single = 1'b1;
                dec_pos    = 6'd38;
            end
        end else if (s1_ovr && (s1_syn <= 6'd38)) begin
            dec_single = 1'b1;
            dec_pos    = s1_syn - 6'd1;
            fixed      = s1_code ^ (39'd1 << (s1_syn - 6'd1));
        end else begin
            // Even overall parity with a nonzero syndrome, or a syndrome that
            // points past the codeword: not correctable, no flip applied.
            dec_double = 1'b1;
        end
        dec_data = extract(fixed);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            data       <= '0;
            single_err <= 1'b0;
            double_err <= 1'b0;
            err_pos    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data       <= dec_data;
                single_err <= dec_single;
                double_err <= dec_double;
                err_pos    <= dec_pos;
            end
        end
    end

    // --------------------------------------------------------------- counters
`ifdef SECDED_DEC_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic out_fire;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire) begin
            if (single_err && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
            if (double_err && (uncorr_cnt != CNT_MAX)) begin
                uncorr_cnt <= uncorr_cnt + CNT_ONE;
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_secded_decoder
//
// Directed and randomized stimulus for secded_decoder (CNT_W = 2). Expected
// results come from a reference that encodes clean data and injects known bit
// flips; the expected decode follows from how many flips were injected and
// where. A negedge monitor pops the expected queue on every output handshake
// and tracks the expected counter values.
// -----------------------------------------------------------------------------
module tb_secded_decoder;

    localparam int CNT_W = 2;
`ifdef SECDED_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [38:0]      enc_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      data;
    logic             single_err;
    logic             double_err;
    logic [5:0]       err_pos;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .enc_data   (enc_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data       (data),
        .single_err (single_err),
        .double_err (double_err),
        .err_pos    (err_pos),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected output tuple: {data[31:0], single, double, err_pos[5:0]}
    logic [39:0]      exp_q[$];
    logic [CNT_W-1:0] exp_corr;
    logic [CNT_W-1:0] exp_uncorr;
    bit               mon_en = 1'b0;
    bit               rnd_rdy = 1'b0;

    // ------------------------------------------------------ reference model
    function automatic bit is_par(input int i);
        return (i == 38) || (((i + 1) & i) == 0);
    endfunction

    function automatic bit bit_of(input logic [38:0] c, input int i);
        return ((c >> i) & 39'd1) != 39'd0;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        int          k;
        bit          p;
        c = '0;
        k = 0;
        for (int i = 0; i < 38; i++) begin
            if (!is_par(i)) begin
                if (((d >> k) & 32'd1) != 32'd0) c = c | (39'd1 << i);
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            p = 1'b0;
            for (int i = 0; i < 38; i++) begin
                if (!is_par(i) && ((((i + 1) >> b) & 1) != 0)) p = p ^ bit_of(c, i);
            end
            if (p) c = c | (39'd1 << ((1 << b) - 1));
        end
        if (^c[37:0]) c = c | (39'd1 << 38);
        return c;
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] c);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int i = 0; i < 38; i++) begin
            if (!is_par(i)) begin
                if (bit_of(c, i)) d = d | (32'd1 << k);
                k++;
            end
        end
        return d;
    endfunction

    // ------------------------------------------------------ driver tasks
    task automatic idle();
        in_valid = 1'b0;
        enc_data = '0;
    endtask

    // Present one codeword and hold it until it is accepted. Returns #1 after
    // the accepting edge with in_valid still high so calls chain back-to-back.
    task automatic drive(input logic [38:0] code, input logic [39:0] exp);
        bit acc;
        bit done;
        in_valid = 1'b1;
        enc_data = code;
        done     = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (rnd_rdy) begin
                out_ready = ($urandom_range(0, 3) != 0);
                cnt_clr   = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (rnd_rdy) cnt_clr = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL drive_timeout got=in_ready_low exp=accept code=%h", code);
            idle();
        end
    endtask

    task automatic wait_drain();
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        idle();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL drain got=%0d_pending exp=0", exp_q.size());
        end
    endtask

    task automatic check_cnts(input string tag, input logic [CNT_W-1:0] c_exp,
                              input logic [CNT_W-1:0] u_exp);
        checks++;
        assert ({corr_cnt, uncorr_cnt} === {c_exp, u_exp}) else begin
            failures++;
            $error("FAIL %s got=%0d/%0d exp=%0d/%0d", tag, corr_cnt, uncorr_cnt, c_exp, u_exp);
        end
    endtask

    // ------------------------------------------------------ scoreboard
    always @(negedge clk) begin
        logic [39:0] e;
        if (!rst_n) begin
            exp_corr   = '0;
            exp_uncorr = '0;
        end else if (mon_en) begin
            checks++;
            assert (corr_cnt === exp_corr) else begin
                failures++;
                $error("FAIL corr_cnt got=%0d exp=%0d", corr_cnt, exp_corr);
            end
            checks++;
            assert (uncorr_cnt === exp_uncorr) else begin
                failures++;
                $error("FAIL uncorr_cnt got=%0d exp=%0d", uncorr_cnt, exp_uncorr);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $error("FAIL unexpected_output got=%h exp=none", data);
                end else begin
                    e = exp_q.pop_front();
                    assert ({data, single_err, double_err, err_pos} === e) else begin
                        failures++;
                        $error("FAIL out_word got=%h/%b/%b/%0d exp=%h/%b/%b/%0d",
                               data, single_err, double_err, err_pos,
                               e[39:8], e[7], e[6], e[5:0]);
                    end
                    if (CNT_EN && !cnt_clr) begin
                        if (e[7] && exp_corr != CNT_MAX) exp_corr = exp_corr + 1'b1;
                        if (e[6] && exp_uncorr != CNT_MAX) exp_uncorr = exp_uncorr + 1'b1;
                    end
                end
            end
            if (CNT_EN && cnt_clr) begin
                exp_corr   = '0;
                exp_uncorr = '0;
            end
        end
    end

    // ------------------------------------------------------ stimulus
    initial begin
        logic [31:0] d;
        logic [38:0] code;
        logic [39:0] exp;
        int          nf;
        int          f1;
        int          f2;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({out_valid, data, single_err, double_err, err_pos, corr_cnt, uncorr_cnt} === '0)
        else begin
            failures++;
            $error("FAIL reset_outputs got=%b/%h/%b/%b/%0d exp=all_zero",
                   out_valid, data, single_err, double_err, err_pos);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL in_ready_after_reset got=%b exp=1", in_ready);
        end
        mon_en = 1'b1;

        // Directed decode cases
        drive(39'h00_0000_0000, {32'h0000_0000, 1'b0, 1'b0, 6'd0});
        drive(39'h40_0000_0007, {32'h0000_0001, 1'b0, 1'b0, 6'd0});
        drive(39'h40_0000_0003, {32'h0000_0001, 1'b1, 1'b0, 6'd2});
        drive(39'h00_0000_0007, {32'h0000_0001, 1'b1, 1'b0, 6'd38});
        drive(39'h40_0000_0013, {32'h0000_0002, 1'b0, 1'b1, 6'd0});
        wait_drain();
        check_cnts("directed_cnts", CNT_EN ? 2'd2 : 2'd0, CNT_EN ? 2'd1 : 2'd0);

        // Clear while idle
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_cnts("idle_clear", 2'd0, 2'd0);

        // Backpressure: only two words fit while the output is stalled
        out_ready = 1'b0;
        drive(39'h40_0000_0003, {32'h0000_0001, 1'b1, 1'b0, 6'd2});
        drive(encode(32'hDEAD_BEEF) ^ (39'd1 << 20),
              {32'hDEAD_BEEF, 1'b1, 1'b0, 6'd20});
        in_valid = 1'b1;
        enc_data = 39'h40_0000_0013;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            assert (in_ready === 1'b0) else begin
                failures++;
                $error("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive(39'h40_0000_0013, {32'h0000_0002, 1'b0, 1'b1, 6'd0});
        drive(encode(32'h1234_5678), {32'h1234_5678, 1'b0, 1'b0, 6'd0});
        wait_drain();
        check_cnts("bp_cnts", CNT_EN ? 2'd2 : 2'd0, CNT_EN ? 2'd1 : 2'd0);

        // Saturation: five single-error words with a 2-bit counter
        for (int n = 0; n < 5; n++) begin
            d = 32'h1000_0000 + n;
            drive(encode(d) ^ (39'd1 << (n + 8)), {d, 1'b1, 1'b0, 6'(n + 8)});
        end
        wait_drain();
        check_cnts("saturate", CNT_EN ? 2'd3 : 2'd0, CNT_EN ? 2'd1 : 2'd0);

        // cnt_clr on the same edge as a single-error handshake
        drive(39'h40_0000_0003, {32'h0000_0001, 1'b1, 1'b0, 6'd2});
        idle();
        for (int c = 0; c < 10 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check_cnts("clr_on_handshake", 2'd0, 2'd0);
        wait_drain();

        // Randomized words with 0, 1 or 2 injected flips and random stalls
        rnd_rdy = 1'b1;
        for (int n = 0; n < 80; n++) begin
            d  = $urandom;
            nf = $urandom_range(0, 2);
            f1 = $urandom_range(0, 38);
            f2 = $urandom_range(0, 38);
            while (f2 == f1) f2 = $urandom_range(0, 38);
            code = encode(d);
            if (nf == 0) begin
                exp = {d, 1'b0, 1'b0, 6'd0};
            end else if (nf == 1) begin
                code = code ^ (39'd1 << f1);
                exp  = {d, 1'b1, 1'b0, 6'(f1)};
            end else begin
                code = code ^ (39'd1 << f1) ^ (39'd1 << f2);
                exp  = {extract(code), 1'b0, 1'b1, 6'd0};
            end
            drive(code, exp);
            if ($urandom_range(0, 3) == 0) idle();
        end
        rnd_rdy = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
